// File: rtl/axi_nport_bridge.sv
// N-port SRAM-like to AXI master bridge: one transaction in flight, line-burst reads, strobed writes.
// Optional AXI_NPORT_RR_ARB_EN selects round-robin arbitration; otherwise lowest index wins.
module axi_nport_bridge #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ID_W       = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [NUM_PORTS-1:0]    req,
  input  logic [NUM_PORTS-1:0]    wr,
  input  logic [NUM_PORTS-1:0]    burst,
  input  logic [2*NUM_PORTS-1:0]  size,
  input  logic [32*NUM_PORTS-1:0] addr,
  input  logic [32*NUM_PORTS-1:0] wdata,
  output logic [31:0]             rdata,
  output logic [NUM_PORTS-1:0]    addr_ok,
  output logic [NUM_PORTS-1:0]    data_ok,
  output logic [ID_W-1:0]         arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_W-1:0]         rid,
  input  logic [31:0]             rdata_axi,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [ID_W-1:0]         awid,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [1:0]              awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ID_W-1:0]         wid,
  output logic [31:0]             wdata_axi,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_W-1:0]         bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int unsigned IdxW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [31:0] LineMask = ~((32'(LINE_WORDS) << 2) - 32'd1);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAwW, StB} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] win, g_q;
  logic            any_req;
  logic            wr_q, burst_q;
  logic [1:0]      size_q;
  logic [31:0]     addr_q, wdata_q;
  logic            aw_done_q, w_done_q;
  logic [31:0]     rdata_q;
  logic [NUM_PORTS-1:0] data_ok_q;

  logic        sel_wr, sel_burst;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;

  // Single outstanding transaction, so response IDs and status carry no information.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, bid, bresp};

`ifdef AXI_NPORT_RR_ARB_EN
  logic [IdxW-1:0] ptr_q;
  int unsigned     idx;

  always_comb begin
    win     = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        win     = IdxW'(idx);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ptr_q <= '0;
    end else if (state_q == StIdle && any_req) begin
      ptr_q <= (32'(win) == NUM_PORTS - 1) ? '0 : win + IdxW'(1);
    end
  end
`else
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!any_req && req[i]) begin
        any_req = 1'b1;
        win     = IdxW'(i);
      end
    end
  end
`endif

  always_comb begin
    sel_wr    = 1'b0;
    sel_burst = 1'b0;
    sel_size  = 2'd0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (IdxW'(i) == win) begin
        sel_wr    = wr[i];
        sel_burst = burst[i];
        sel_size  = size[2*i +: 2];
        sel_addr  = addr[32*i +: 32];
        sel_wdata = wdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    addr_ok = '0;
    if (aresetn && state_q == StIdle && any_req) addr_ok[win] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = sel_wr ? StAwW : StAr;
      StAr:    if (arready) state_d = StR;
      StR:     if (rvalid && rlast) state_d = StIdle;
      StAwW:   if ((aw_done_q || awready) && (w_done_q || wready)) state_d = StB;
      StB:     if (bvalid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      g_q       <= '0;
      wr_q      <= 1'b0;
      burst_q   <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      data_ok_q <= '0;
    end else begin
      state_q   <= state_d;
      data_ok_q <= '0;
      case (state_q)
        StIdle: begin
          if (any_req) begin
            g_q       <= win;
            wr_q      <= sel_wr;
            burst_q   <= sel_burst & ~sel_wr;
            // Size 3 is carried as a word access from here on.
            size_q    <= (sel_size == 2'd3) ? 2'd2 : sel_size;
            addr_q    <= sel_addr;
            wdata_q   <= sel_wdata;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        StR: begin
          if (rvalid) begin
            rdata_q        <= rdata_axi;
            data_ok_q[g_q] <= 1'b1;
          end
        end
        StAwW: begin
          if (awready) aw_done_q <= 1'b1;
          if (wready)  w_done_q  <= 1'b1;
        end
        StB: begin
          if (bvalid) data_ok_q[g_q] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (size_q)
      2'd0:    wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb = 4'b0011 << {addr_q[1], 1'b0};
      default: wstrb = 4'b1111;
    endcase
  end

  assign arvalid = (state_q == StAr);
  assign arid    = ID_W'(g_q);
  assign araddr  = burst_q ? (addr_q & LineMask) : addr_q;
  assign arlen   = burst_q ? 8'(LINE_WORDS - 1) : 8'd0;
  assign arsize  = burst_q ? 3'b010 : {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = (state_q == StR);

  assign awvalid   = (state_q == StAwW) && !aw_done_q;
  assign awid      = ID_W'(g_q);
  assign awaddr    = addr_q;
  assign awlen     = 8'd0;
  assign awsize    = {1'b0, size_q};
  assign awburst   = 2'b01;
  assign awlock    = 2'b00;
  assign awcache   = 4'd0;
  assign awprot    = 3'd0;
  assign wvalid    = (state_q == StAwW) && !w_done_q;
  assign wid       = ID_W'(g_q);
  assign wdata_axi = wdata_q;
  assign wlast     = 1'b1;
  assign bready    = (state_q == StB);

  assign rdata   = rdata_q;
  assign data_ok = data_ok_q;

  logic unused_wr;
  assign unused_wr = wr_q;

endmodule

// File: tb/tb_axi_nport_bridge.sv
// Directed bench for axi_nport_bridge: table of single transactions plus hand-written corner cases.
module tb_axi_nport_bridge;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [1:0]  req, wr, burst, addr_ok, data_ok;
  logic [3:0]  size;
  logic [63:0] addr, wdata;
  logic [31:0] rdata;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata_axi, wdata_axi;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_nport_bridge dut (
    .aclk(clk), .aresetn(aresetn), .req(req), .wr(wr), .burst(burst), .size(size),
    .addr(addr), .wdata(wdata), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid), .awready(awready), .wid(wid),
    .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    int          port;
    logic        wr;
    logic        burst;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] base;
    int          beats;
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;
    logic [2:0]  exp_size;
    logic [3:0]  exp_strb;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] onehot(input int port);
    logic [31:0] v;
    v = '0;
    v[port] = 1'b1;
    return v;
  endfunction

  task automatic issue(input int port, input logic w, input logic b, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    req[port]              = 1'b1;
    wr[port]               = w;
    burst[port]            = b;
    size[2*port +: 2]      = sz;
    addr[32*port +: 32]    = a;
    wdata[32*port +: 32]   = d;
    #1;
    while (addr_ok[port] !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("addr_ok", 32'(addr_ok), onehot(port));
    @(negedge clk);
    req[port] = 1'b0;
  endtask

  task automatic do_read(input int port, input logic b, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] base, input int beats,
                         input logic [31:0] exp_addr, input logic [7:0] exp_len,
                         input logic [2:0] exp_size);
    issue(port, 1'b0, b, sz, a, 32'd0);
    check("arvalid", 32'(arvalid), 32'd1);
    check("araddr", araddr, exp_addr);
    check("arlen", 32'(arlen), 32'(exp_len));
    check("arsize", 32'(arsize), 32'(exp_size));
    check("arid", 32'(arid), 32'(port));
    check("arburst", 32'(arburst), 32'd1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("rready", 32'(rready), 32'd1);
    check("arvalid_drop", 32'(arvalid), 32'd0);
    for (int i = 0; i < beats; i++) begin
      rvalid    = 1'b1;
      rdata_axi = base + 32'(i);
      rlast     = (i == beats - 1);
      @(negedge clk);
      rvalid = 1'b0;
      rlast  = 1'b0;
      check("r_data_ok", 32'(data_ok), onehot(port));
      check("r_rdata", rdata, base + 32'(i));
    end
    check("r_done", 32'(rready), 32'd0);
    @(negedge clk);
    check("r_quiet", 32'(data_ok), 32'd0);
  endtask

  task automatic do_write(input int port, input logic b, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] exp_size, input logic [3:0] exp_strb);
    issue(port, 1'b1, b, sz, a, d);
    check("awvalid", 32'(awvalid), 32'd1);
    check("wvalid", 32'(wvalid), 32'd1);
    check("awaddr", awaddr, a);
    check("awlen", 32'(awlen), 32'd0);
    check("awsize", 32'(awsize), 32'(exp_size));
    check("wstrb", 32'(wstrb), 32'(exp_strb));
    check("wlast", 32'(wlast), 32'd1);
    check("wdata", wdata_axi, d);
    check("awid", 32'(awid), 32'(port));
    check("wid", 32'(wid), 32'(port));
    awready = 1'b1;
    wready  = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    wready  = 1'b0;
    check("b_bready", 32'(bready), 32'd1);
    check("b_valids", 32'({awvalid, wvalid}), 32'd0);
    check("b_early", 32'(data_ok), 32'd0);
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    check("w_data_ok", 32'(data_ok), onehot(port));
    @(negedge clk);
    check("w_quiet", 32'(data_ok), 32'd0);
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
  endtask

  initial begin
    int          cnt0, cnt1, win, exp_port, n;
    aresetn = 1'b0;
    req = '0; wr = '0; burst = '0; size = '0; addr = '0; wdata = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata_axi = '0; rid = '0; rresp = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;

    // Reset state, with a request pending that must not be accepted.
    req[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_addr_ok", 32'(addr_ok), 32'd0);
    check("rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
    check("rst_data_ok", 32'(data_ok), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    req[0]  = 1'b0;
    aresetn = 1'b1;
    @(negedge clk);

    vecs[0] = '{0, 1'b0, 1'b0, 2'd2, 32'h1FC0_0004, 32'h0, 32'hDEAD_BEEF, 1,
                32'h1FC0_0004, 8'd0, 3'd2, 4'h0};
    vecs[1] = '{1, 1'b0, 1'b1, 2'd2, 32'h8000_0014, 32'h0, 32'h0, 8,
                32'h8000_0000, 8'd7, 3'd2, 4'h0};
    vecs[2] = '{1, 1'b0, 1'b0, 2'd0, 32'h0000_1003, 32'h0, 32'h0000_00A5, 1,
                32'h0000_1003, 8'd0, 3'd0, 4'h0};
    vecs[3] = '{0, 1'b1, 1'b0, 2'd1, 32'h0000_0102, 32'h1234_0000, 32'h0, 0,
                32'h0, 8'd0, 3'd1, 4'b1100};
    vecs[4] = '{0, 1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 0,
                32'h0, 8'd0, 3'd2, 4'b1111};
    vecs[5] = '{1, 1'b1, 1'b0, 2'd0, 32'h0000_0301, 32'h0000_7700, 32'h0, 0,
                32'h0, 8'd0, 3'd0, 4'b0010};
    vecs[6] = '{1, 1'b1, 1'b1, 2'd0, 32'hBFAF_F002, 32'h0011_0000, 32'h0, 0,
                32'h0, 8'd0, 3'd0, 4'b0100};
    vecs[7] = '{0, 1'b0, 1'b1, 2'd2, 32'h1FC0_001C, 32'h0, 32'h0000_0100, 8,
                32'h1FC0_0000, 8'd7, 3'd2, 4'h0};

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr)
        do_write(vecs[i].port, vecs[i].burst, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_size, vecs[i].exp_strb);
      else
        do_read(vecs[i].port, vecs[i].burst, vecs[i].size, vecs[i].addr, vecs[i].base,
                vecs[i].beats, vecs[i].exp_addr, vecs[i].exp_len, vecs[i].exp_size);
    end

    // Byte write with awready arriving two cycles after wready.
    issue(1, 1'b1, 1'b0, 2'd0, 32'hBFAF_F003, 32'hAB00_0000);
    check("bw_wstrb", 32'(wstrb), 32'b1000);
    check("bw_awsize", 32'(awsize), 32'd0);
    check("bw_awlen", 32'(awlen), 32'd0);
    check("bw_wlast", 32'(wlast), 32'd1);
    wready = 1'b1;
    @(negedge clk);
    wready = 1'b0;
    check("bw_w_drop", 32'({awvalid, wvalid}), 32'b10);
    @(negedge clk);
    check("bw_aw_hold", 32'({awvalid, bready}), 32'b10);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    check("bw_bready", 32'({awvalid, bready}), 32'b01);
    check("bw_no_ok", 32'(data_ok), 32'd0);
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    check("bw_data_ok", 32'(data_ok), 32'b10);
    @(negedge clk);
    check("bw_single", 32'(data_ok), 32'd0);

    // Early rlast on the second beat of a line read.
    do_read(1, 1'b1, 2'd2, 32'h8000_0040, 32'h0000_0900, 2, 32'h8000_0040, 8'd7, 3'd2);

    // Reset during R after three of eight beats.
    issue(0, 1'b0, 1'b1, 2'd2, 32'h1FC0_0040, 32'h0);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rvalid    = 1'b1;
      rdata_axi = 32'h0000_0A00 + 32'(i);
      @(negedge clk);
    end
    check("mid_beat3", 32'(data_ok), 32'b01);
    aresetn   = 1'b0;
    rdata_axi = 32'h0000_0A03;
    @(negedge clk);
    rvalid = 1'b0;
    check("mid_rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
    check("mid_rst_data_ok", 32'(data_ok), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    aresetn = 1'b1;
    @(negedge clk);
    check("mid_rst_quiet", 32'(data_ok), 32'd0);
    do_read(1, 1'b0, 2'd2, 32'h0000_0010, 32'h0000_0B00, 1, 32'h0000_0010, 8'd0, 3'd2);

    // Both ports requesting continuously, four reads each, from a fresh pointer.
    apply_reset();
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < 8; k++) begin
      size = 4'b1010;
      req  = {cnt1 < 4, cnt0 < 4};
      n    = 0;
      #1;
      while (addr_ok == 2'b00 && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
`ifdef AXI_NPORT_RR_ARB_EN
      exp_port = k % 2;
`else
      exp_port = (k < 4) ? 0 : 1;
`endif
      check("arb_grant", 32'(addr_ok), onehot(exp_port));
      win = addr_ok[1] ? 1 : 0;
      if (win == 1) cnt1++;
      else cnt0++;
      @(negedge clk);
      req = {cnt1 < 4, cnt0 < 4};
      check("arb_arid", 32'(arid), 32'(exp_port));
      arready = 1'b1;
      @(negedge clk);
      arready   = 1'b0;
      rvalid    = 1'b1;
      rlast     = 1'b1;
      rdata_axi = 32'(k);
      @(negedge clk);
      rvalid = 1'b0;
      rlast  = 1'b0;
      check("arb_data_ok", 32'(data_ok), onehot(exp_port));
    end
    req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
